uart_slot_sched: RTL and testbench
==================================

// Module: uart_slot_sched
// PURPOSE
//  Bus master for one UART MMIO slot (addr 0 status/rx read, 1 divisor write, 2 tx write, 3 rx pop).
//  Programs the baud divisor after reset and on request, then shares the TX path among NUM_REQ byte
//  requesters (round-robin) and drains the RX FIFO into one valid/ready consumer port.
//  Sits between on-chip byte producers/consumers and the UART slot; no CPU involvement.
// PARAMETERS
//  NUM_REQ    4       number of TX requesters (1..8)
//  DVSR_INIT  650     11-bit divisor written after reset (100 MHz, 9600 baud, 16x oversample)
//  CFG_GUARD  16384   cycles TX granting is frozen before a runtime divisor write (line drain)
// PORTS
//  clk         in   1           clock
//  reset       in   1           asynchronous, active-high reset
//  cs          out  1           slot select
//  read        out  1           slot read strobe
//  write       out  1           slot write strobe
//  addr        out  2           slot register address
//  wr_data     out  32          slot write data (divisor in [10:0], tx byte in [7:0])
//  rd_data     in   32          slot read data, combinational: [9]=tx_full [8]=rx_empty [7:0]=rx byte
//  req_valid   in   NUM_REQ     requester i has a byte
//  req_data    in   8*NUM_REQ   byte of requester i at [8i+7:8i]
//  req_ready   out  NUM_REQ     one-hot pulse: byte of requester i written this cycle
//  rx_valid    out  1           rx_data holds an unconsumed byte
//  rx_data     out  8           received byte
//  rx_ready    in   1           consumer accepts rx_data when rx_valid && rx_ready
//  dvsr_set    in   1           pulse: request divisor change to dvsr_new
//  dvsr_new    in   11          new divisor, sampled when dvsr_set=1
//  cfg_busy    out  1           high in INIT, CFG_WAIT, CFG_WR
//  tx_count    out  16          bytes written to TX, wraps 0xFFFF->0
// BEHAVIOUR
//  States: WAIT -> INIT -> RUN <-> CFG_WAIT -> CFG_WR -> RUN. Reset (any time) -> WAIT.
//  Reset values: state=WAIT, rr_ptr=0, rx_valid=0, rx_data=0, tx_count=0, guard cnt=0, pend=0.
//  WAIT: slot idle (cs=read=write=0, addr=0, wr_data=0); 1 cycle, ensures no write during reset.
//  INIT: 1 cycle, cs=1 write=1 addr=1 wr_data=DVSR_INIT; -> RUN.
//  RUN, every cycle: cs=1 read=1 addr=0 by default; status taken combinationally from rd_data.
//   At most one slot write per cycle; priority: divisor request > RX drain > TX grant.
//   RX drain: if rx_empty=0 and (rx_valid=0 or rx_ready=1): write=1 addr=3 (pop), rx_data<=rd_data[7:0],
//    rx_valid<=1 next cycle. Consume-and-refill same cycle allowed (no bubble).
//   rx_valid clears on rx_valid&&rx_ready when no refill. RX FIFO never popped while holding unconsumed byte.
//   TX grant (no pop this cycle, tx_full=0): first i at/after rr_ptr (mod NUM_REQ) with req_valid[i];
//    write=1 addr=2 wr_data={24'h0,byte_i}; req_ready[i]=1; rr_ptr<=i+1 mod NUM_REQ; tx_count+=1.
//   tx_full=1 or no valid requester: req_ready=0, rr_ptr holds. Back-to-back grants allowed.
//  dvsr_set: latch dvsr_new into pend register (later pulse overwrites). If state RUN -> CFG_WAIT.
//   Pulse in WAIT/INIT/CFG_*: latched, served on next entry to RUN (CFG_WAIT entered from RUN).
//  CFG_WAIT: TX grants frozen, RX drain continues; counts CFG_GUARD cycles, then -> CFG_WR.
//  CFG_WR: 1 cycle, write=1 addr=1 wr_data={21'h0,pend}; clears pend flag; -> RUN.
//  req_ready is 0 outside RUN. cfg_busy=0 only in RUN. Reset mid-write aborts it; slot idles at once.
// TESTING
//  Reset release -> WAIT 1 cycle idle, then exactly one write addr=1 data=650, cfg_busy falls.
//  req_valid=4'b1011, tx_full=0 held -> grants req 0,1,3,0,1,3; tx_count increments by 1 each.
//  tx_full=1 for 5 cycles with req_valid=4'b0001 -> no write/req_ready; grant on first tx_full=0 cycle.
//  rx_empty=0 bytes 0x41,0x42, rx_ready=0 -> one pop, rx_data=0x41 held; rx_ready=1 -> pop 0x42 same cycle.
//  dvsr_set dvsr_new=0x145 (CFG_GUARD=8) -> 8 cycles no grants, then write addr=1 data=0x145, grants resume.
//  rx_empty=0 and req_valid=1 same cycle -> pop first, TX grant next cycle; reset mid-CFG_WAIT -> re-INIT 650.

Source files
------------

// File: rtl/uart_slot_sched.sv
// UART MMIO slot bus master: programs the baud divisor, round-robins TX bytes from
// NUM_REQ requesters and drains the RX FIFO into a single valid/ready consumer port.
module uart_slot_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DVSR_INIT = 650,
  parameter int CFG_GUARD = 16384
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   cs,
  output logic                   read,
  output logic                   write,
  output logic [1:0]             addr,
  output logic [31:0]            wr_data,
  input  logic [31:0]            rd_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rx_valid,
  output logic [7:0]             rx_data,
  input  logic                   rx_ready,
  input  logic                   dvsr_set,
  input  logic [10:0]            dvsr_new,
  output logic                   cfg_busy,
  output logic [15:0]            tx_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(CFG_GUARD + 1);

  localparam logic [2:0] ST_WAIT     = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_CFG_WAIT = 3'd3;
  localparam logic [2:0] ST_CFG_WR   = 3'd4;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_DVSR   = 2'd1;
  localparam logic [1:0] A_TX     = 2'd2;
  localparam logic [1:0] A_RX_POP = 2'd3;

  localparam logic [10:0]      DVSR_INIT_L = 11'(DVSR_INIT);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(CFG_GUARD - 1);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [PTR_W-1:0] rr_ptr_r;
  logic             rx_valid_r;
  logic [7:0]       rx_data_r;
  logic [15:0]      tx_count_r;
  logic [CNT_W-1:0] guard_cnt_r;
  logic [10:0]      pend_r;
  logic             pend_valid_r;

  logic             tx_full_s;
  logic             rx_empty_s;
  logic             rx_ok_s;
  logic             pop_s;
  logic             grant_s;
  logic             grant_found_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic [PTR_W-1:0] cand_s;
  logic             unused_rd_s;

  assign tx_full_s   = rd_data[9];
  assign rx_empty_s  = rd_data[8];
  assign unused_rd_s = ^rd_data[31:10];
  assign rx_ok_s     = !rx_empty_s && (!rx_valid_r || rx_ready);

  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;
  assign tx_count = tx_count_r;
  assign cfg_busy = (state_r != ST_RUN);

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr_r.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = wrap_idx(rr_ptr_r, k);
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Slot bus decode and next-state; at most one slot write per cycle.
  always_comb begin
    cs          = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    addr        = A_STATUS;
    wr_data     = 32'h0000_0000;
    req_ready   = '0;
    pop_s       = 1'b0;
    grant_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT: begin
        state_nxt_s = ST_INIT;
      end
      ST_INIT: begin
        cs          = 1'b1;
        write       = 1'b1;
        addr        = A_DVSR;
        wr_data     = {21'h0, DVSR_INIT_L};
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        cs   = 1'b1;
        read = 1'b1;
        if (dvsr_set || pend_valid_r) begin
          state_nxt_s = ST_CFG_WAIT;
        end else if (rx_ok_s) begin
          pop_s = 1'b1;
          read  = 1'b0;
          write = 1'b1;
          addr  = A_RX_POP;
        end else if (grant_found_s && !tx_full_s) begin
          grant_s   = 1'b1;
          read      = 1'b0;
          write     = 1'b1;
          addr      = A_TX;
          wr_data   = {24'h0, req_data[{grant_idx_s, 3'b000} +: 8]};
          req_ready = NUM_REQ'(1) << grant_idx_s;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_CFG_WAIT: begin
        cs   = 1'b1;
        read = 1'b1;
        if (rx_ok_s) begin
          pop_s = 1'b1;
          read  = 1'b0;
          write = 1'b1;
          addr  = A_RX_POP;
        end else begin
          pop_s = 1'b0;
        end
        if (guard_cnt_r == GUARD_LAST) begin
          state_nxt_s = ST_CFG_WR;
        end else begin
          state_nxt_s = ST_CFG_WAIT;
        end
      end
      ST_CFG_WR: begin
        cs          = 1'b1;
        write       = 1'b1;
        addr        = A_DVSR;
        wr_data     = {21'h0, pend_r};
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_WAIT;
      end
    endcase
  end

  // State, arbitration pointer and TX byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_WAIT;
      rr_ptr_r   <= '0;
      tx_count_r <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        rr_ptr_r   <= (grant_idx_s == PTR_LAST) ? '0 : grant_idx_s + PTR_W'(1);
        tx_count_r <= tx_count_r + 16'd1;
      end else begin
        rr_ptr_r   <= rr_ptr_r;
        tx_count_r <= tx_count_r;
      end
    end
  end

  // RX holding register; a pop refills it even while the old byte is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
    end else if (pop_s) begin
      rx_valid_r <= 1'b1;
      rx_data_r  <= rd_data[7:0];
    end else if (rx_valid_r && rx_ready) begin
      rx_valid_r <= 1'b0;
      rx_data_r  <= rx_data_r;
    end else begin
      rx_valid_r <= rx_valid_r;
      rx_data_r  <= rx_data_r;
    end
  end

  // Line-drain guard counter, pending divisor value and its request flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guard_cnt_r  <= '0;
      pend_r       <= 11'h000;
      pend_valid_r <= 1'b0;
    end else begin
      if (state_r == ST_CFG_WAIT && guard_cnt_r != GUARD_LAST) begin
        guard_cnt_r <= guard_cnt_r + CNT_W'(1);
      end else begin
        guard_cnt_r <= '0;
      end
      if (dvsr_set) begin
        pend_r       <= dvsr_new;
        pend_valid_r <= 1'b1;
      end else if (state_r == ST_CFG_WR) begin
        pend_r       <= pend_r;
        pend_valid_r <= 1'b0;
      end else begin
        pend_r       <= pend_r;
        pend_valid_r <= pend_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_slot_sched.sv
// Directed bench for uart_slot_sched: vector table for arbitration/RX flow plus
// hand-written sequences for divisor programming and reset corner cases.
module tb_uart_slot_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        dvsr_set;
  logic [10:0] dvsr_new;
  logic        cfg_busy;
  logic [15:0] tx_count;

  logic        tx_full, rx_empty;
  logic [7:0]  rx_byte;
  int          checks = 0;
  int          errors = 0;

  assign rd_data = {22'h0, tx_full, rx_empty, rx_byte};

  always #5 clk = ~clk;

  uart_slot_sched #(.NUM_REQ(4), .DVSR_INIT(650), .CFG_GUARD(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .dvsr_set(dvsr_set), .dvsr_new(dvsr_new), .cfg_busy(cfg_busy), .tx_count(tx_count)
  );

  typedef struct {
    logic [3:0]  rv;
    logic        tf;
    logic        re;
    logic [7:0]  rb;
    logic        rr;
    logic        ewr;
    logic [1:0]  ea;
    logic [7:0]  ewd;
    logic [3:0]  erdy;
    logic        erxv;
    logic [7:0]  erxd;
    logic [15:0] etxc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] rv, logic tf, logic re, logic [7:0] rb, logic rr,
                              logic ewr, logic [1:0] ea, logic [7:0] ewd, logic [3:0] erdy,
                              logic erxv, logic [7:0] erxd, logic [15:0] etxc);
    vec_t v;
    v.rv = rv; v.tf = tf; v.re = re; v.rb = rb; v.rr = rr;
    v.ewr = ewr; v.ea = ea; v.ewd = ewd; v.erdy = erdy;
    v.erxv = erxv; v.erxd = erxd; v.etxc = etxc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Release reset and walk WAIT (idle) -> INIT (divisor write) -> RUN.
  task automatic init_seq(input string tag);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk({tag, " wait cs"}, 32'(cs), 32'd0);
    chk({tag, " wait write"}, 32'(write), 32'd0);
    next_cycle();
    @(negedge clk);
    chk({tag, " init write"}, 32'(write), 32'd1);
    chk({tag, " init addr"}, 32'(addr), 32'd1);
    chk({tag, " init data"}, wr_data, 32'd650);
    chk({tag, " init busy"}, 32'(cfg_busy), 32'd1);
    next_cycle();
    @(negedge clk);
    chk({tag, " run busy"}, 32'(cfg_busy), 32'd0);
    chk({tag, " run read"}, 32'(read), 32'd1);
    chk({tag, " run write"}, 32'(write), 32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 4'h0; tx_full = 1'b0; rx_empty = 1'b1; rx_byte = 8'h00;
    rx_ready = 1'b0; dvsr_set = 1'b0; dvsr_new = 11'h000;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // round robin over 1011, then tx_full backpressure
    tbl.push_back(mk(4'hB, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA0, 4'h1, 1'b0, 8'h00, 16'd0));
    tbl.push_back(mk(4'hB, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA1, 4'h2, 1'b0, 8'h00, 16'd1));
    tbl.push_back(mk(4'hB, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA3, 4'h8, 1'b0, 8'h00, 16'd2));
    tbl.push_back(mk(4'hB, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA0, 4'h1, 1'b0, 8'h00, 16'd3));
    tbl.push_back(mk(4'hB, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA1, 4'h2, 1'b0, 8'h00, 16'd4));
    tbl.push_back(mk(4'hB, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA3, 4'h8, 1'b0, 8'h00, 16'd5));
    for (int n = 0; n < 5; n++)
      tbl.push_back(mk(4'h1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h00, 16'd6));
    tbl.push_back(mk(4'h1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA0, 4'h1, 1'b0, 8'h00, 16'd6));
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h00, 16'd7));
    // RX drain: hold while unconsumed, refill on consume, clear on consume without refill
    tbl.push_back(mk(4'h0, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1, 2'd3, 8'h00, 4'h0, 1'b0, 8'h00, 16'd7));
    tbl.push_back(mk(4'h0, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 8'h41, 16'd7));
    tbl.push_back(mk(4'h0, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 8'h41, 16'd7));
    tbl.push_back(mk(4'h0, 1'b0, 1'b0, 8'h42, 1'b1, 1'b1, 2'd3, 8'h00, 4'h0, 1'b1, 8'h41, 16'd7));
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 8'h42, 16'd7));
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 8'h42, 16'd7));
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h42, 16'd7));
    // pop beats a pending TX grant; grant follows next cycle
    tbl.push_back(mk(4'h1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 2'd3, 8'h00, 4'h0, 1'b0, 8'h42, 16'd7));
    tbl.push_back(mk(4'h1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 2'd2, 8'hA0, 4'h1, 1'b1, 8'h55, 16'd7));
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h55, 16'd8));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset cs", 32'(cs), 32'd0);
    chk("reset write", 32'(write), 32'd0);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    chk("reset rx_data", 32'(rx_data), 32'd0);
    chk("reset tx_count", 32'(tx_count), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    init_seq("por");

    foreach (tbl[i]) begin
      req_valid = tbl[i].rv; tx_full = tbl[i].tf; rx_empty = tbl[i].re;
      rx_byte = tbl[i].rb; rx_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d write", i), 32'(write), 32'(tbl[i].ewr));
      chk($sformatf("v%0d addr", i), 32'(addr), 32'(tbl[i].ea));
      chk($sformatf("v%0d wr_data", i), wr_data, {24'h0, tbl[i].ewd});
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].erdy));
      chk($sformatf("v%0d rx_valid", i), 32'(rx_valid), 32'(tbl[i].erxv));
      chk($sformatf("v%0d rx_data", i), 32'(rx_data), 32'(tbl[i].erxd));
      chk($sformatf("v%0d tx_count", i), 32'(tx_count), 32'(tbl[i].etxc));
      next_cycle();
    end

    // runtime divisor change: request cycle and guard window grant nothing, RX still drains
    req_valid = 4'hF; rx_empty = 1'b1; rx_ready = 1'b1; rx_byte = 8'h66;
    dvsr_set = 1'b1; dvsr_new = 11'h145;
    @(negedge clk);
    chk("cfg req write", 32'(write), 32'd0);
    chk("cfg req ready", 32'(req_ready), 32'd0);
    next_cycle();
    dvsr_set = 1'b0;
    for (int w = 1; w <= 8; w++) begin
      rx_empty = (w == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk($sformatf("guard%0d busy", w), 32'(cfg_busy), 32'd1);
      chk($sformatf("guard%0d req_ready", w), 32'(req_ready), 32'd0);
      chk($sformatf("guard%0d write", w), 32'(write), 32'(w == 3));
      if (w == 3) chk("guard pop addr", 32'(addr), 32'd3);
      if (w == 4) chk("guard rx_data", {23'h0, rx_valid, rx_data}, 32'h166);
      next_cycle();
    end
    rx_empty = 1'b1;
    @(negedge clk);
    chk("cfg wr write", 32'(write), 32'd1);
    chk("cfg wr addr", 32'(addr), 32'd1);
    chk("cfg wr data", wr_data, 32'h145);
    chk("cfg wr req_ready", 32'(req_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("resume busy", 32'(cfg_busy), 32'd0);
    chk("resume data", wr_data, 32'hA1);
    chk("resume req_ready", 32'(req_ready), 32'h2);
    chk("resume tx_count", 32'(tx_count), 32'd8);
    next_cycle();
    @(negedge clk);
    chk("resume2 req_ready", 32'(req_ready), 32'h4);
    chk("resume2 tx_count", 32'(tx_count), 32'd9);
    next_cycle();

    // reset in the middle of CFG_WAIT, then reset during the INIT write
    req_valid = 4'h0; dvsr_set = 1'b1; dvsr_new = 11'h0AA;
    next_cycle();
    dvsr_set = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("mid cfg busy", 32'(cfg_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async rst cs", 32'(cs), 32'd0);
    chk("async rst tx_count", 32'(tx_count), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("re wait write", 32'(write), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("re init data", wr_data, 32'd650);
    chk("re init write", 32'(write), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort write", 32'(write), 32'd0);
    chk("abort cs", 32'(cs), 32'd0);
    init_seq("re");
    req_valid = 4'hF;
    @(negedge clk);
    chk("post rst req_ready", 32'(req_ready), 32'h1);
    chk("post rst data", wr_data, 32'hA0);
    next_cycle();
    @(negedge clk);
    chk("post rst tx_count", 32'(tx_count), 32'd1);
    chk("post rst next grant", 32'(req_ready), 32'h2);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
